pkt_unpacker: RTL and testbench
===============================

// Module: pkt_unpacker
// PURPOSE
// - Receive-side counterpart of the reward packer: deserializes an 8-word incoming packet
//   from the radio/CSMA/TDMA front end into named fields.
// - Classifies each packet (type, destination match, broadcast) and either presents it
//   to packetFilter / neighborTable / MY_NODE_INFO with a valid/ack handshake, or drops it.
// - Packet word order, identical to the transmit side: 0 {13'b0,pktType[2:0]}, 1 sourceID,
//   2 destinationID, 3 energyLeft, 4 QValue, 5 sourceHops, 6 chosenCH, 7 hopsFromCH.
// PARAMETERS
// - WORD_WIDTH  16  width of every packet word and field
// - PKT_WORDS   8   words per packet; counter width is $clog2(PKT_WORDS)
// - RX_TIMEOUT  15  idle cycles allowed between accepted words of one packet before abort
// PORTS
// - clk             in   1   system clock; one clock domain
// - nrst            in   1   asynchronous, active-low reset
// - en              in   1   receiver enable; gates the start of a new packet only
// - myNodeID        in   WW  own node ID, used for destination and self-echo checks
// - rx_valid        in   1   rx_word valid this cycle
// - rx_word         in   WW  incoming packet word
// - rx_ready        out  1   unpacker can accept a word this cycle
// - pkt_ack         in   1   consumer has taken the presented packet
// - pkt_valid       out  1   f* fields hold a complete, accepted packet
// - pkt_drop        out  1   one-cycle pulse: packet discarded
// - drop_reason     out  2   00 none, 01 bad type, 10 self echo, 11 timeout
// - fPacketType     out  3   word0[2:0]
// - fSourceID, fDestinationID, fEnergyLeft, fQValue, fSourceHops, fChosenCH,
//   fHopsFromCH      out  WW  words 1..7
// - iAmDestination  out  1   fDestinationID == myNodeID
// - isBroadcast     out  1   fDestinationID == 16'hFFFF
// BEHAVIOUR
// - Reset values: state IDLE; rx_ready 0; pkt_valid 0; pkt_drop 0; drop_reason 00;
//   fPacketType 3'b111; fDestinationID 16'hFFFF; all other f* 0; flags 0; counters 0.
// - Handshake: a word is accepted on a rising edge where rx_valid && rx_ready.
// - rx_ready is registered and reads 1 only in IDLE with en=1, and in RECV.
// - FSM states IDLE -> RECV -> CHECK -> HOLD, plus CHECK -> IDLE on drop.
// - IDLE: an accepted word is word 0 -> RECV; wcnt=1; tmo=RX_TIMEOUT.
// - RECV: each accepted word is stored into the field selected by wcnt; wcnt++;
//   tmo reloads to RX_TIMEOUT.
// - RECV: a cycle with no accepted word decrements tmo.
// - RECV: tmo==0 with no word -> pkt_drop=1 for one cycle, drop_reason=11, go to IDLE.
//   Stored fields keep their stale values; pkt_valid stays 0.
// - RECV: acceptance of word PKT_WORDS-1 -> CHECK; rx_ready falls the next cycle.
//   wcnt wraps to 0.
// - CHECK, one cycle; drop checks take priority in this order:
//   - fPacketType==3'b111 -> drop, reason 01.
//   - fSourceID==myNodeID -> drop, reason 10.
//   - Otherwise -> HOLD.
// - A drop from CHECK pulses pkt_drop for one cycle and returns to IDLE.
// - iAmDestination and isBroadcast are registered in CHECK.
// - Latency: pkt_valid=1 on the 2nd rising edge after the last-word handshake edge.
// - HOLD: pkt_valid=1; fields and flags stable; rx_ready=0 (backpressure).
// - HOLD: pkt_ack=1 -> pkt_valid=0 and IDLE on the next edge.
//   pkt_ack during the first HOLD cycle is legal.
// - pkt_ack outside HOLD is ignored.
// - en=0 mid-packet does not abort; the packet completes through CHECK/HOLD, and no new
//   packet starts until en=1.
// - drop_reason holds its last value until the next drop or reset. pkt_drop and pkt_valid
//   are never both 1.
// - The unpacker does no type-specific filtering (HB lock, hop checks). Those stay in
//   packetFilter and reward.
// - Reset asserted mid-operation returns everything to reset values immediately; the
//   partial packet is lost and no pkt_drop is issued.
// TESTING
// - myNodeID=5: send 8 back-to-back words {0005?type=101, src 3, dst 5, 200, 40, 2, 7, 1}
//   -> pkt_valid 2 cycles after word 7; iAmDestination=1; fields match; ack clears it.
// - HB broadcast, dst 16'hFFFF, with rx_valid gaps of 3 cycles between words
//   -> accepted; isBroadcast=1; iAmDestination=0.
// - Stop after word 4 -> pkt_drop pulse exactly RX_TIMEOUT+1 cycles after word 4;
//   drop_reason=11; next packet is received cleanly.
// - type=111 -> pkt_drop with reason 01.
// - src=myNodeID=5 -> pkt_drop with reason 10; pkt_valid never asserts.
// - Hold pkt_ack=0 for 20 cycles while the sender offers words -> rx_ready=0 and fields
//   stable; then ack -> rx_ready=1 the next cycle.
// - Toggle en=0 at word 3 -> packet still completes.
// - Assert nrst at word 5 -> reset values; no drop pulse.

Source files
------------

// File: rtl/pkt_unpacker_if.sv
// Receive-word handshake plus presented-packet fields between the radio front end, the unpacker and its consumers.
// slave is the unpacker side, master is the front end / consumer side.
interface pkt_unpacker_if #(
   parameter int WORD_WIDTH = 16
);
   logic                  rx_valid;
   logic [WORD_WIDTH-1:0] rx_word;
   logic                  rx_ready;
   logic                  pkt_ack;
   logic                  pkt_valid;
   logic                  pkt_drop;
   logic [1:0]            drop_reason;
   logic [2:0]            fPacketType;
   logic [WORD_WIDTH-1:0] fSourceID;
   logic [WORD_WIDTH-1:0] fDestinationID;
   logic [WORD_WIDTH-1:0] fEnergyLeft;
   logic [WORD_WIDTH-1:0] fQValue;
   logic [WORD_WIDTH-1:0] fSourceHops;
   logic [WORD_WIDTH-1:0] fChosenCH;
   logic [WORD_WIDTH-1:0] fHopsFromCH;
   logic                  iAmDestination;
   logic                  isBroadcast;

   modport slave (
      input  rx_valid, rx_word, pkt_ack,
      output rx_ready, pkt_valid, pkt_drop, drop_reason,
      output fPacketType, fSourceID, fDestinationID, fEnergyLeft,
      output fQValue, fSourceHops, fChosenCH, fHopsFromCH,
      output iAmDestination, isBroadcast
   );

   modport master (
      output rx_valid, rx_word, pkt_ack,
      input  rx_ready, pkt_valid, pkt_drop, drop_reason,
      input  fPacketType, fSourceID, fDestinationID, fEnergyLeft,
      input  fQValue, fSourceHops, fChosenCH, fHopsFromCH,
      input  iAmDestination, isBroadcast
   );
endinterface

// File: rtl/pkt_unpacker.sv
// Deserialises an 8-word rx packet into named fields, classifies it, then holds it for a valid/ack consumer or drops it.
// pkt_valid rises two edges after the last-word handshake; rx_ready stays low from the last word until ack.
module pkt_unpacker #(
   parameter int WORD_WIDTH = 16,
   parameter int PKT_WORDS  = 8,
   parameter int RX_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   pkt_unpacker_if.slave         bus
);
   localparam int WCNT_W = $clog2(PKT_WORDS);
   localparam int TMO_W  = $clog2(RX_TIMEOUT + 1);
   localparam logic [WCNT_W-1:0]     LAST_WORD = WCNT_W'(PKT_WORDS - 1);
   localparam logic [TMO_W-1:0]      TMO_LOAD  = TMO_W'(RX_TIMEOUT);
   localparam logic [WORD_WIDTH-1:0] BCAST_ID  = '1;
   localparam logic [2:0]            TYPE_BAD  = 3'b111;
   localparam logic [1:0]            DR_TYPE   = 2'b01;
   localparam logic [1:0]            DR_ECHO   = 2'b10;
   localparam logic [1:0]            DR_TMO    = 2'b11;

   typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CHECK = 2'd2, HOLD = 2'd3} state_t;
   state_t state, state_nxt;

   logic [WCNT_W-1:0]     wcnt;
   logic [TMO_W-1:0]      tmo;
   logic                  rx_ready, pkt_valid, pkt_drop;
   logic [1:0]            drop_reason;
   logic [2:0]            pkt_type;
   logic [WORD_WIDTH-1:0] src_id, dst_id, energy, qvalue, src_hops, chosen_ch, hops_ch;
   logic                  i_am_dst, is_bcast;

   logic                  rx_ready_nxt, pkt_valid_nxt, pkt_drop_nxt;
   logic [1:0]            drop_reason_nxt;
   logic                  accept, last_word, tmo_exp, bad_type, self_echo, reject;

   assign accept    = bus.rx_valid && rx_ready;
   assign last_word = accept && (wcnt == LAST_WORD);
   assign tmo_exp   = (state == RECV) && rx_ready && !accept && (tmo == '0);
   assign bad_type  = (pkt_type == TYPE_BAD);
   assign self_echo = (src_id == myNodeID);
   assign reject    = (state == CHECK) && (bad_type || self_echo);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   // RECV with rx_ready low means the last word is already stored; that cycle registers it before CHECK.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RECV;
         RECV:    if (tmo_exp) state_nxt = IDLE;
                  else if (!rx_ready) state_nxt = CHECK;
         CHECK:   state_nxt = (bad_type || self_echo) ? IDLE : HOLD;
         HOLD:    if (bus.pkt_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_ready_nxt    = ((state_nxt == IDLE) && en) || ((state_nxt == RECV) && !last_word);
      pkt_valid_nxt   = (state_nxt == HOLD);
      pkt_drop_nxt    = tmo_exp || reject;
      drop_reason_nxt = drop_reason;
      if (tmo_exp)     drop_reason_nxt = DR_TMO;
      else if (reject) drop_reason_nxt = bad_type ? DR_TYPE : DR_ECHO;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_ready    <= 1'b0;
         pkt_valid   <= 1'b0;
         pkt_drop    <= 1'b0;
         drop_reason <= 2'b00;
         wcnt        <= '0;
         tmo         <= '0;
         pkt_type    <= TYPE_BAD;
         src_id      <= '0;
         dst_id      <= BCAST_ID;
         energy      <= '0;
         qvalue      <= '0;
         src_hops    <= '0;
         chosen_ch   <= '0;
         hops_ch     <= '0;
         i_am_dst    <= 1'b0;
         is_bcast    <= 1'b0;
      end else begin
         rx_ready    <= rx_ready_nxt;
         pkt_valid   <= pkt_valid_nxt;
         pkt_drop    <= pkt_drop_nxt;
         drop_reason <= drop_reason_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  pkt_type <= bus.rx_word[2:0];
                  wcnt     <= WCNT_W'(1);
                  tmo      <= TMO_LOAD;
               end
            end
            RECV: begin
               if (accept) begin
                  case (wcnt)
                     WCNT_W'(1): src_id    <= bus.rx_word;
                     WCNT_W'(2): dst_id    <= bus.rx_word;
                     WCNT_W'(3): energy    <= bus.rx_word;
                     WCNT_W'(4): qvalue    <= bus.rx_word;
                     WCNT_W'(5): src_hops  <= bus.rx_word;
                     WCNT_W'(6): chosen_ch <= bus.rx_word;
                     WCNT_W'(7): hops_ch   <= bus.rx_word;
                     default:    ;
                  endcase
                  wcnt <= (wcnt == LAST_WORD) ? '0 : wcnt + WCNT_W'(1);
                  tmo  <= TMO_LOAD;
               end else if (tmo_exp) begin
                  wcnt <= '0;
               end else if (rx_ready) begin
                  tmo <= tmo - TMO_W'(1);
               end
            end
            CHECK: begin
               i_am_dst <= (dst_id == myNodeID);
               is_bcast <= (dst_id == BCAST_ID);
            end
            default: ;
         endcase
      end
   end

   assign bus.rx_ready       = rx_ready;
   assign bus.pkt_valid      = pkt_valid;
   assign bus.pkt_drop       = pkt_drop;
   assign bus.drop_reason    = drop_reason;
   assign bus.fPacketType    = pkt_type;
   assign bus.fSourceID      = src_id;
   assign bus.fDestinationID = dst_id;
   assign bus.fEnergyLeft    = energy;
   assign bus.fQValue        = qvalue;
   assign bus.fSourceHops    = src_hops;
   assign bus.fChosenCH      = chosen_ch;
   assign bus.fHopsFromCH    = hops_ch;
   assign bus.iAmDestination = i_am_dst;
   assign bus.isBroadcast    = is_bcast;
endmodule

// File: tb/tb_pkt_unpacker.sv
// Bench for pkt_unpacker: vector table, directed multi-cycle corner cases, then random packets against an outcome model.
module tb_pkt_unpacker;
   localparam int RX_TIMEOUT = 15;

   logic        clk;
   logic        nrst;
   logic        en;
   logic [15:0] my_id;
   int          checks;
   int          failures;

   pkt_unpacker_if #(.WORD_WIDTH(16)) bus ();

   pkt_unpacker #(.WORD_WIDTH(16), .PKT_WORDS(8), .RX_TIMEOUT(RX_TIMEOUT)) dut (
      .clk      (clk),
      .nrst     (nrst),
      .en       (en),
      .myNodeID (my_id),
      .bus      (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   typedef logic [7:0][15:0] words_t;

   typedef struct {
      string      name;
      words_t     w;
      int         gap;
      logic [15:0] my;
      bit         exp_valid;
      logic [1:0] exp_reason;
      bit         exp_dest;
      bit         exp_bcast;
   } vec_t;

   vec_t   vt[7];
   words_t good;
   words_t rw;
   words_t snap;
   int     lat;
   bit     gv;
   bit     gd;
   bit     seen;
   logic [1:0] last_reason;
   logic [1:0] verd;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic words_t mk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
      words_t w;
      w[0] = a0; w[1] = a1; w[2] = a2; w[3] = a3;
      w[4] = a4; w[5] = a5; w[6] = a6; w[7] = a7;
      return w;
   endfunction

   function automatic vec_t mkv(input string n, input words_t w, input int gap, input logic [15:0] my,
                                input bit ev, input logic [1:0] er, input bit ed, input bit eb);
      vec_t v;
      v.name = n; v.w = w; v.gap = gap; v.my = my;
      v.exp_valid = ev; v.exp_reason = er; v.exp_dest = ed; v.exp_bcast = eb;
      return v;
   endfunction

   function automatic words_t cur_fields();
      words_t f;
      f[0] = {13'd0, bus.fPacketType};
      f[1] = bus.fSourceID;
      f[2] = bus.fDestinationID;
      f[3] = bus.fEnergyLeft;
      f[4] = bus.fQValue;
      f[5] = bus.fSourceHops;
      f[6] = bus.fChosenCH;
      f[7] = bus.fHopsFromCH;
      return f;
   endfunction

   // Outcome of a complete packet from the classification rules: 0 accept, 1 bad type, 2 self echo.
   function automatic logic [1:0] verdict(input words_t w, input logic [15:0] my);
      logic [15:0] w0;
      w0 = w[0];
      if (w0[2:0] == 3'b111) return 2'b01;
      if (w[1] == my) return 2'b10;
      return 2'b00;
   endfunction

   task automatic put_word(input logic [15:0] w);
      int n;
      n = 0;
      bus.rx_valid = 1'b1;
      bus.rx_word  = w;
      while (!bus.rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("rx_ready_wait", 128'(bus.rx_ready), 128'(1));
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_words(input words_t w, input int first, input int last, input int gap, input bit rnd);
      for (int i = first; i <= last; i++) begin
         if (i > first) begin
            int g;
            g = rnd ? int'($urandom_range(0, 2)) : gap;
            repeat (g) @(negedge clk);
         end
         put_word(w[i]);
      end
   endtask

   task automatic wait_result(output int l, output bit v, output bit d);
      l = 0;
      while (!(bus.pkt_valid || bus.pkt_drop) && l < 40) begin
         @(negedge clk);
         l++;
      end
      v = bus.pkt_valid;
      d = bus.pkt_drop;
      chk("valid_drop_exclusive", 128'(bus.pkt_valid & bus.pkt_drop), 128'(0));
   endtask

   task automatic do_ack();
      bus.pkt_ack = 1'b1;
      @(negedge clk);
      bus.pkt_ack = 1'b0;
      chk("ack_clears_valid", 128'(bus.pkt_valid), 128'(0));
   endtask

   initial begin
      checks = 0;
      failures = 0;
      nrst = 1'b0;
      en = 1'b1;
      my_id = 16'd5;
      bus.rx_valid = 1'b0;
      bus.rx_word = 16'd0;
      bus.pkt_ack = 1'b0;
      good = mk(16'd5, 16'd3, 16'd5, 16'd200, 16'd40, 16'd2, 16'd7, 16'd1);

      vt[0] = mkv("basic",     good, 0, 16'd5, 1'b1, 2'b00, 1'b1, 1'b0);
      vt[1] = mkv("bcast_gap3", mk(16'd1, 16'd9, 16'hFFFF, 16'd100, 16'd20, 16'd3, 16'd9, 16'd2),
                  3, 16'd5, 1'b1, 2'b00, 1'b0, 1'b1);
      vt[2] = mkv("bad_type",  mk(16'd7, 16'd3, 16'd5, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5),
                  0, 16'd5, 1'b0, 2'b01, 1'b0, 1'b0);
      vt[3] = mkv("self_echo", mk(16'd2, 16'd5, 16'd9, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5),
                  1, 16'd5, 1'b0, 2'b10, 1'b0, 1'b0);
      vt[4] = mkv("both_bad",  mk(16'd7, 16'd5, 16'd5, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5),
                  0, 16'd5, 1'b0, 2'b01, 1'b0, 1'b0);
      vt[5] = mkv("gap15",     mk(16'd4, 16'd8, 16'd6, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15),
                  RX_TIMEOUT, 16'd5, 1'b1, 2'b01, 1'b0, 1'b0);
      vt[6] = mkv("my_is_ffff", mk(16'd2, 16'd3, 16'hFFFF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5),
                  0, 16'hFFFF, 1'b1, 2'b01, 1'b1, 1'b1);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rx_ready", 128'(bus.rx_ready), 128'(0));
      chk("rst_pkt_valid", 128'(bus.pkt_valid), 128'(0));
      chk("rst_pkt_drop", 128'(bus.pkt_drop), 128'(0));
      chk("rst_drop_reason", 128'(bus.drop_reason), 128'(0));
      chk("rst_fields", 128'(cur_fields()), 128'(mk(16'd7, 16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0)));
      chk("rst_flags", 128'({bus.iAmDestination, bus.isBroadcast}), 128'(0));
      nrst = 1'b1;
      @(negedge clk);
      chk("idle_rx_ready", 128'(bus.rx_ready), 128'(1));

      for (int i = 0; i < 7; i++) begin
         my_id = vt[i].my;
         send_words(vt[i].w, 0, 7, vt[i].gap, 1'b0);
         wait_result(lat, gv, gd);
         chk({vt[i].name, "_latency"}, 128'(lat), 128'(2));
         chk({vt[i].name, "_valid"}, 128'(gv), 128'(vt[i].exp_valid));
         chk({vt[i].name, "_drop"}, 128'(gd), 128'(!vt[i].exp_valid));
         chk({vt[i].name, "_reason"}, 128'(bus.drop_reason), 128'(vt[i].exp_reason));
         if (vt[i].exp_valid) begin
            chk({vt[i].name, "_fields"}, 128'(cur_fields()), 128'(vt[i].w));
            chk({vt[i].name, "_dest"}, 128'(bus.iAmDestination), 128'(vt[i].exp_dest));
            chk({vt[i].name, "_bcast"}, 128'(bus.isBroadcast), 128'(vt[i].exp_bcast));
            do_ack();
         end else begin
            @(negedge clk);
            chk({vt[i].name, "_drop_pulse"}, 128'(bus.pkt_drop), 128'(0));
            chk({vt[i].name, "_no_valid"}, 128'(bus.pkt_valid), 128'(0));
         end
      end

      // Timeout: sender stalls after word 4
      my_id = 16'd5;
      send_words(good, 0, 4, 0, 1'b0);
      lat = 0;
      while (!bus.pkt_drop && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk("tmo_latency", 128'(lat), 128'(RX_TIMEOUT + 1));
      chk("tmo_reason", 128'(bus.drop_reason), 128'(3));
      chk("tmo_no_valid", 128'(bus.pkt_valid), 128'(0));
      @(negedge clk);
      chk("tmo_drop_pulse", 128'(bus.pkt_drop), 128'(0));
      send_words(good, 0, 7, 0, 1'b0);
      wait_result(lat, gv, gd);
      chk("after_tmo_valid", 128'(gv), 128'(1));
      chk("after_tmo_fields", 128'(cur_fields()), 128'(good));
      do_ack();

      // Backpressure in HOLD while the sender keeps offering a word
      send_words(good, 0, 7, 0, 1'b0);
      wait_result(lat, gv, gd);
      snap = cur_fields();
      bus.rx_valid = 1'b1;
      bus.rx_word = 16'hABCD;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | bus.rx_ready | (cur_fields() != snap) | !bus.pkt_valid;
      end
      chk("hold_stable_no_ready", 128'(seen), 128'(0));
      chk("hold_fields", 128'(cur_fields()), 128'(good));
      bus.pkt_ack = 1'b1;
      @(negedge clk);
      bus.pkt_ack = 1'b0;
      chk("hold_ack_ready", 128'(bus.rx_ready), 128'(1));
      chk("hold_ack_valid", 128'(bus.pkt_valid), 128'(0));
      bus.rx_valid = 1'b0;

      // en dropped mid-packet
      send_words(good, 0, 3, 0, 1'b0);
      en = 1'b0;
      send_words(good, 4, 7, 0, 1'b0);
      wait_result(lat, gv, gd);
      chk("en_off_valid", 128'(gv), 128'(1));
      chk("en_off_fields", 128'(cur_fields()), 128'(good));
      do_ack();
      repeat (5) @(negedge clk);
      chk("en_off_no_ready", 128'(bus.rx_ready), 128'(0));
      en = 1'b1;
      @(negedge clk);
      chk("en_on_ready", 128'(bus.rx_ready), 128'(1));

      // Reset after word 5
      send_words(good, 0, 5, 0, 1'b0);
      nrst = 1'b0;
      #1;
      chk("midrst_rx_ready", 128'(bus.rx_ready), 128'(0));
      chk("midrst_reason", 128'(bus.drop_reason), 128'(0));
      chk("midrst_fields", 128'(cur_fields()), 128'(mk(16'd7, 16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0)));
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | bus.pkt_drop | bus.pkt_valid;
      end
      chk("midrst_no_drop", 128'(seen), 128'(0));
      send_words(good, 0, 7, 0, 1'b0);
      wait_result(lat, gv, gd);
      chk("midrst_next_valid", 128'(gv), 128'(1));
      do_ack();

      // Random packets against the outcome model
      last_reason = 2'b00;
      for (int k = 0; k < 40; k++) begin
         int sel;
         my_id = ($urandom_range(0, 1) == 0) ? 16'd5 : 16'($urandom);
         for (int i = 3; i < 8; i++) rw[i] = 16'($urandom);
         rw[0] = {13'd0, 3'($urandom_range(0, 7))};
         rw[1] = ($urandom_range(0, 3) == 0) ? my_id : 16'($urandom);
         sel = int'($urandom_range(0, 2));
         rw[2] = (sel == 0) ? my_id : (sel == 1) ? 16'hFFFF : 16'($urandom);
         send_words(rw, 0, 7, 0, 1'b1);
         wait_result(lat, gv, gd);
         verd = verdict(rw, my_id);
         if (verd != 2'b00) last_reason = verd;
         chk("rnd_latency", 128'(lat), 128'(2));
         chk("rnd_valid", 128'(gv), 128'(verd == 2'b00));
         chk("rnd_drop", 128'(gd), 128'(verd != 2'b00));
         chk("rnd_reason", 128'(bus.drop_reason), 128'(last_reason));
         if (gv) begin
            chk("rnd_fields", 128'(cur_fields()), 128'(rw));
            chk("rnd_dest", 128'(bus.iAmDestination), 128'(rw[2] == my_id));
            chk("rnd_bcast", 128'(bus.isBroadcast), 128'(rw[2] == 16'hFFFF));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rnd_valid_held", 128'(bus.pkt_valid), 128'(1));
            do_ack();
         end else begin
            @(negedge clk);
            chk("rnd_drop_pulse", 128'(bus.pkt_drop), 128'(0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
